mult: RTL and testbench

Multi-cycle 32×32 signed multiplier for the datapath's HI/LO unit; the multiply-side counterpart of the iterative divider. It is started by a one-cycle `mult` pulse from the control unit. It runs a radix-2 Booth recurrence, one step per clock. It writes the 64-bit product to `high`/`low` and pulses `mult_end` so the control FSM can leave its wait state.

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_if.sv | 30 +++
 rtl/mult_booth_step.sv | 24 ++
 rtl/mult.sv | 81 ++++++++
 tb/tb_mult.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the Booth multiplier
//   state_e    : controller states IDLE/RUN
//   MULT_STEPS : Booth steps per operation
//   ACC_W      : accumulator width
//   EXT_W      : extended operand width
package mult_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;
    localparam int MULT_STEPS = 33;
    localparam int ACC_W = 34;
    localparam int EXT_W = 33;
endpackage

// File: rtl/mult_if.sv
// mult_if: start/operand/result bundle between control unit and multiplier
//   master (control unit): drives mult, a, b [, multu]; reads high, low, mult_end, busy
//   slave  (multiplier)  : the reverse
//   multu exists only when MULT_MULTU_EN is defined
interface mult_if #(parameter int WIDTH = 32);
    logic             mult;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] low;
    logic             mult_end;
    logic             busy;
`ifdef MULT_MULTU_EN
    logic             multu;
`endif
    modport master (
`ifdef MULT_MULTU_EN
        output multu,
`endif
        output mult, a, b,
        input  high, low, mult_end, busy
    );
    modport slave (
`ifdef MULT_MULTU_EN
        input  multu,
`endif
        input  mult, a, b,
        output high, low, mult_end, busy
    );
endinterface

// File: rtl/mult_booth_step.sv
// booth_step: one combinational radix-2 Booth step
//   i_aqq : current {A, Q, q-1}
//   i_m   : extended multiplicand M
//   o_aqq : {A +/- M, Q, q-1} arithmetically shifted right by one
module booth_step
    import mult_pkg::*;
(
    input  logic [ACC_W+EXT_W:0] i_aqq,
    input  logic [EXT_W-1:0]     i_m,
    output logic [ACC_W+EXT_W:0] o_aqq
);
    logic [ACC_W-1:0] w_a;
    logic [ACC_W-1:0] w_m;
    logic [ACC_W-1:0] w_sum;

    assign w_a = i_aqq[ACC_W+EXT_W:EXT_W+1];
    assign w_m = {i_m[EXT_W-1], i_m};

    always_comb begin
        w_sum = (i_aqq[1:0] == 2'b10) ? w_a - w_m :
                (i_aqq[1:0] == 2'b01) ? w_a + w_m : w_a;
        o_aqq = {w_sum[ACC_W-1], w_sum, i_aqq[EXT_W:1]};
    end
endmodule

// File: rtl/mult.sv
// mult: multi-cycle 32x32 signed (optionally unsigned) Booth multiplier
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mult_if slave (mult, a, b [, multu] in; high, low, mult_end, busy out)
//   Define MULT_MULTU_EN to add the multu (zero-extend) select.
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic clk,
    input  logic reset,
    mult_if.slave bus
);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]             r_state;
    logic [5:0]             r_cnt;
    logic [EXT_W-1:0]       r_m;
    logic [ACC_W+EXT_W:0]   r_aqq;
    logic [WIDTH-1:0]       r_high;
    logic [WIDTH-1:0]       r_low;
    logic                   r_end;
    logic                   w_sx;
    logic [EXT_W-1:0]       w_ext_a;
    logic [EXT_W-1:0]       w_ext_b;
    logic [ACC_W+EXT_W:0]   w_next;

`ifdef MULT_MULTU_EN
    assign w_sx = ~bus.multu;
`else
    assign w_sx = 1'b1;
`endif

    assign w_ext_a = {bus.a[WIDTH-1] & w_sx, bus.a};
    assign w_ext_b = {bus.b[WIDTH-1] & w_sx, bus.b};

    booth_step u_step (
        .i_aqq (r_aqq),
        .i_m   (r_m),
        .o_aqq (w_next)
    );

    // Product is {A,Q}[63:0], i.e. w_next without the trailing q-1 bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_aqq   <= '0;
            r_high  <= '0;
            r_low   <= '0;
            r_end   <= 1'b0;
        end else begin
            r_end <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (bus.mult) begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                    r_m     <= w_ext_a;
                    r_aqq   <= {{ACC_W{1'b0}}, w_ext_b, 1'b0};
                end
            end else begin
                r_aqq <= w_next;
                r_cnt <= r_cnt + 6'd1;
                if (r_cnt == 6'(MULT_STEPS - 1)) begin
                    r_state <= ST_IDLE;
                    r_high  <= w_next[2*WIDTH:WIDTH+1];
                    r_low   <= w_next[WIDTH:1];
                    r_end   <= 1'b1;
                end
            end
        end
    end

    assign bus.high     = r_high;
    assign bus.low      = r_low;
    assign bus.mult_end = r_end;
    assign bus.busy     = (r_state == ST_RUN);
endmodule

// File: tb/tb_mult.sv
// tb_mult: scoreboard bench for the Booth multiplier
module tb_mult;
    typedef struct {
        logic [63:0] p;
        int          c;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    logic   prev_end = 1'b0;
    exp_t   sb[$];

    mult_if #(.WIDTH(32)) bus ();

    mult #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every mult_end pulse must match the next queued result and its completion cycle.
    always @(negedge clk) begin
        if (bus.mult_end) begin
            if (prev_end) chk("mult_end_width", 64'd2, 64'd1);
            if (sb.size() == 0) chk("unexpected_mult_end", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", {bus.high, bus.low}, e.p);
                chk("latency", 64'(cyc), 64'(e.c));
            end
        end
        prev_end = bus.mult_end;
    end

    // Called at a negedge; the following posedge is the start edge E0.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic u,
                         input logic [63:0] p, input bit push);
        exp_t e;
        bus.mult = 1'b1;
        bus.a = a;
        bus.b = b;
`ifdef MULT_MULTU_EN
        bus.multu = u;
`else
        if (u) $display("multu ignored in this build");
`endif
        e.p = p;
        e.c = cyc + 34;
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.mult = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic u, input logic [63:0] p);
        start(a, b, u, p, 1'b1);
        wait_done();
    endtask

    initial begin
        bus.mult = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef MULT_MULTU_EN
        bus.multu = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.high, bus.low}, 64'd0);
        chk("reset_flags", {62'd0, bus.mult_end, bus.busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        run(32'hFFFF_FFF9, 32'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        run(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        run(32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0);
`ifdef MULT_MULTU_EN
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001);
`endif

        // A start while busy is ignored and operands are not recaptured.
        start(32'd2, 32'd2, 1'b0, 64'd4, 1'b1);
        repeat (8) @(negedge clk);
        bus.mult = 1'b1;
        bus.a = 32'd9;
        @(negedge clk);
        bus.mult = 1'b0;
        wait_done();

        // Asynchronous reset mid-run: outputs clear at once, no completion.
        start(32'd6, 32'd7, 1'b0, 64'd42, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {bus.high, bus.low}, 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_busy", 64'(bus.busy), 64'd0);
        run(32'd6, 32'd7, 1'b0, 64'd42);

        // Back-to-back: start again in the mult_end cycle.
        start(32'd5, 32'd5, 1'b0, 64'd25, 1'b1);
        for (int i = 0; i < 60 && !bus.mult_end; i++) @(negedge clk);
        chk("b2b_end_seen", 64'(bus.mult_end), 64'd1);
        start(32'd4, 32'd4, 1'b0, 64'd16, 1'b1);
        repeat (5) @(negedge clk);
        chk("b2b_held", {bus.high, bus.low}, 64'd25);
        wait_done();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
